// File: rtl/efdr_encoder.sv
// rtl/efdr_encoder.sv - serial EFDR run-length encoder
// Splits a raw bit stream into runs and emits one type/prefix/tail codeword per run.
module efdr_encoder #(
  parameter int CNT_W = 6,
  parameter int G_W   = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  input  logic in_valid,
  input  logic in_last,
  output logic in_ready,
  output logic bit_out,
  output logic out_valid,
  input  logic out_ready,
  output logic out_last,
  output logic cw_done,
  output logic ovf_err
);

  localparam logic [CNT_W-1:0] L_MAX = CNT_W'((2 ** CNT_W) - 2);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_TYPE, S_PREFIX, S_TAIL} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic [G_W-1:0]   r_g;
  logic [CNT_W-1:0] r_t;
  logic [G_W-1:0]   r_pos;
  logic             r_ovf;

  logic             w_accept;
  logic             w_take;
  logic             w_load;
  logic             w_ovf_set;
  logic             w_prefix_end;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_len1;
  logic [CNT_W-1:0] w_pow;
  logic [G_W-1:0]   w_g;
  logic [CNT_W-1:0] w_t;

  function automatic logic [G_W-1:0] f_log2(input logic [CNT_W-1:0] v);
    f_log2 = '0;
    for (int i = 0; i < CNT_W; i++) begin
      if (v[i]) f_log2 = G_W'(i);
    end
  endfunction

  assign in_ready     = reset && (r_state == S_IDLE || r_state == S_RUN);
  assign out_valid    = (r_state == S_TYPE) || (r_state == S_PREFIX) || (r_state == S_TAIL);
  assign w_accept     = in_valid && in_ready;
  assign w_take       = out_valid && out_ready;
  assign w_prefix_end = (r_pos == r_g - G_W'(1));
  assign out_last     = (r_state == S_TAIL) && (r_pos == '0) && r_last;
  assign cw_done      = w_take && (r_state == S_TAIL) && (r_pos == '0);
  assign ovf_err      = r_ovf;

  // Group and tail are derived from the final run length, captured on entry to TYPE.
  assign w_len1 = w_cnt_nxt + CNT_W'(1);
  assign w_g    = f_log2(w_len1);
  assign w_pow  = CNT_W'(1) << w_g;
  assign w_t    = w_len1 - w_pow;

  always_comb begin
    bit_out = 1'b0;
    case (r_state)
      S_TYPE:   bit_out = r_b;
      S_PREFIX: bit_out = !w_prefix_end;
      S_TAIL:   bit_out = r_t[r_pos];
      default:  bit_out = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_ovf_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt = CNT_W'(1);
          if (in_last) begin
            w_state_nxt = S_TYPE;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (w_accept) begin
          w_state_nxt = S_TYPE;
          w_load      = 1'b1;
          if (bit_in == r_b) begin
            // A same-valued bit at L_MAX closes the run like a terminator.
            if (r_cnt == L_MAX) begin
              w_ovf_set = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
              if (!in_last) begin
                w_state_nxt = S_RUN;
                w_load      = 1'b0;
              end
            end
          end
        end
      end
      S_TYPE:   if (w_take) w_state_nxt = S_PREFIX;
      S_PREFIX: if (w_take && w_prefix_end) w_state_nxt = S_TAIL;
      S_TAIL:   if (w_take && r_pos == '0) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_b    <= 1'b0;
      r_cnt  <= '0;
      r_last <= 1'b0;
      r_g    <= '0;
      r_t    <= '0;
      r_pos  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt  <= w_cnt_nxt;
        r_last <= in_last;
      end
      if (r_state == S_IDLE && w_accept) r_b <= bit_in;
      if (w_load) begin
        r_g <= w_g;
        r_t <= w_t;
      end
      if (w_ovf_set) r_ovf <= 1'b1;
      case (r_state)
        S_TYPE: if (w_take) r_pos <= '0;
        S_PREFIX: begin
          if (w_take) begin
            if (w_prefix_end) r_pos <= r_g - G_W'(1);
            else              r_pos <= r_pos + G_W'(1);
          end
        end
        S_TAIL: begin
          if (w_take) begin
            r_pos <= r_pos - G_W'(1);
            if (r_pos == '0) r_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_efdr_encoder.sv
// tb/tb_efdr_encoder.sv - directed and randomized bench for efdr_encoder
// Expected codewords come from a run-parsing reference model over the stimulus stream.
module tb_efdr_encoder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic bit_in = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, bit_out, out_valid, out_last, cw_done, ovf_err;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;

  bit stim[$];
  bit stim_last;
  bit exp_ovf;
  bit exp_bit[$], exp_done[$], exp_lst[$];
  bit got_bit[$], got_done[$], got_lst[$];
  bit stall_prev = 1'b0;
  bit bit_prev = 1'b0;

  efdr_encoder dut (
    .clk(clk), .reset(reset),
    .bit_in(bit_in), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .bit_out(bit_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .cw_done(cw_done), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Downstream readiness changes just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (reset) begin
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_bit", bit_out, bit_prev);
      end
      if (out_valid && out_ready) begin
        got_bit.push_back(bit_out);
        got_done.push_back(cw_done);
        got_lst.push_back(out_last);
      end
      stall_prev = out_valid && !out_ready;
      bit_prev   = bit_out;
    end else begin
      stall_prev = 1'b0;
    end
  end

  function automatic void emit(input bit b, input int k, input bit lst);
    int g = 0;
    int t;
    while ((1 << (g + 1)) <= k + 1) g++;
    t = k + 1 - (1 << g);
    exp_bit.push_back(b); exp_done.push_back(0); exp_lst.push_back(0);
    for (int j = 0; j < g; j++) begin
      exp_bit.push_back(j < g - 1); exp_done.push_back(0); exp_lst.push_back(0);
    end
    for (int j = g - 1; j >= 0; j--) begin
      exp_bit.push_back(1'((t >> j) & 1));
      exp_done.push_back(j == 0);
      exp_lst.push_back(lst && j == 0);
    end
  endfunction

  function automatic void model();
    int n = stim.size();
    int i = 0;
    while (i < n) begin
      bit b = stim[i];
      int k = 1;
      bit lst = stim_last && (i == n - 1);
      i++;
      while (!lst && i < n) begin
        lst = stim_last && (i == n - 1);
        if (stim[i] == b && k < 62) begin
          k++;
          i++;
        end else begin
          if (stim[i] == b) exp_ovf = 1'b1;
          i++;
          break;
        end
      end
      emit(b, k, lst);
    end
  endfunction

  task automatic feed();
    for (int i = 0; i < stim.size(); i++) begin
      int w = 0;
      @(negedge clk);
      bit_in   = stim[i];
      in_valid = 1'b1;
      in_last  = stim_last && (i == stim.size() - 1);
      while (!in_ready && w < 500) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        chk("feed_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    bit_in   = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int w = 0;
    while (got_bit.size() < exp_bit.size() && w < 5000) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_len"}, got_bit.size(), exp_bit.size());
    for (int i = 0; i < exp_bit.size() && i < got_bit.size(); i++) begin
      chk({tag, "_bit"}, got_bit[i], exp_bit[i]);
      chk({tag, "_done"}, got_done[i], exp_done[i]);
      chk({tag, "_last"}, got_lst[i], exp_lst[i]);
    end
    exp_bit.delete(); exp_done.delete(); exp_lst.delete();
    got_bit.delete(); got_done.delete(); got_lst.delete();
  endtask

  task automatic run_test(input string tag);
    model();
    feed();
    wait_out(tag);
  endtask

  initial begin
    exp_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {in_ready, out_valid, bit_out, out_last, cw_done, ovf_err}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    chk("idle_valid", out_valid, 0);

    // Shortest run with latency and input-stall timing.
    rdy_mode = 0;
    stim = '{1'b0, 1'b1}; stim_last = 1'b0;
    model();
    feed();
    chk("t1_ready_c1", in_ready, 0);
    chk("t1_type_valid", out_valid, 1);
    chk("t1_type_bit", bit_out, 0);
    @(negedge clk);
    chk("t1_ready_c2", in_ready, 0);
    @(negedge clk);
    chk("t1_ready_c3", in_ready, 0);
    chk("t1_cw_done", cw_done, 1);
    @(negedge clk);
    chk("t1_ready_back", in_ready, 1);
    wait_out("t1");

    stim = '{1'b1, 1'b1, 1'b1, 1'b0}; stim_last = 1'b0;
    run_test("t2");

    stim.delete();
    repeat (62) stim.push_back(1'b0);
    stim.push_back(1'b1); stim_last = 1'b0;
    run_test("t3");
    chk("t3_no_ovf", ovf_err, 0);

    rdy_mode = 1;
    stim = '{1'b1, 1'b1, 1'b1, 1'b0}; stim_last = 1'b0;
    run_test("t5");
    rdy_mode = 0;

    stim = '{1'b1, 1'b1}; stim_last = 1'b1;
    run_test("t6");

    stim.delete();
    repeat (63) stim.push_back(1'b0);
    stim_last = 1'b0;
    run_test("t4");
    chk("t4_ovf", ovf_err, 1);
    chk("t4_model_ovf", ovf_err, exp_ovf);

    // Reset in the middle of a codeword tail.
    stim.delete();
    repeat (62) stim.push_back(1'b0);
    stim.push_back(1'b1); stim_last = 1'b0;
    model();
    feed();
    begin
      int w = 0;
      while (got_bit.size() < 8 && w < 200) begin
        @(negedge clk);
        w++;
      end
    end
    chk("t7_reach_tail", got_bit.size() >= 8, 1);
    #2 reset = 1'b0;
    #1 chk("t7_reset_outs", {in_ready, out_valid, bit_out, out_last, cw_done, ovf_err}, 0);
    exp_bit.delete(); exp_done.delete(); exp_lst.delete();
    got_bit.delete(); got_done.delete(); got_lst.delete();
    exp_ovf = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stim = '{1'b0, 1'b1}; stim_last = 1'b0;
    run_test("t7b");
    chk("t7_ovf_clear", ovf_err, 0);

    rdy_mode = 2;
    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(20, 150);
      bit b = 1'($urandom_range(0, 1));
      stim.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 7) == 0) b = ~b;
        stim.push_back(b);
      end
      stim_last = 1'b1;
      run_test("rnd");
      chk("rnd_ovf", ovf_err, exp_ovf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
